// File: rtl/cx_mixer.sv
// Complex mixer: (in_i + j*in_q) * (lo_i + j*lo_q) on one shared multiplier.
// Optional macro CX_MIXER_CONJ_EN adds a conj input that mixes with conj(LO).
module cx_mixer #(
    parameter int DSZ   = 16,
    parameter int GUARD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef CX_MIXER_CONJ_EN
    input  logic                  conj,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [DSZ-1:0] in_i,
    input  logic signed [DSZ-1:0] in_q,
    input  logic signed [DSZ-1:0] lo_i,
    input  logic signed [DSZ-1:0] lo_q,
    output logic                  out_valid,
    output logic signed [DSZ-1:0] out_i,
    output logic signed [DSZ-1:0] out_q,
    output logic                  ovf
);

    localparam int AW = 2*DSZ + GUARD;
    localparam int HW = AW - DSZ + 2;
    localparam logic signed [AW:0] RND_K =
        {{(AW+2-DSZ){1'b0}}, 1'b1, {(DSZ-2){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DRAIN,
        S_RND,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]              r_cnt;
    logic [1:0]              r_pidx;
    logic                    r_pvld;
    logic signed [DSZ-1:0]   r_in_i;
    logic signed [DSZ-1:0]   r_in_q;
    logic signed [DSZ-1:0]   r_lo_i;
    logic signed [DSZ-1:0]   r_lo_q;
    logic signed [2*DSZ-1:0] r_prod;
    logic signed [AW-1:0]    r_acc_i;
    logic signed [AW-1:0]    r_acc_q;
    logic signed [DSZ-1:0]   r_out_i;
    logic signed [DSZ-1:0]   r_out_q;
    logic                    r_ovf;
`ifdef CX_MIXER_CONJ_EN
    logic                    r_conj;
`endif

    logic                    w_accept;
    logic                    w_neg;
    logic signed [DSZ-1:0]   w_mul_a;
    logic signed [DSZ-1:0]   w_mul_b;
    logic signed [2*DSZ-1:0] w_prod;
    logic signed [AW-1:0]    w_pext;
    logic signed [AW-1:0]    w_addend;
    logic signed [AW:0]      w_rnd_i;
    logic signed [AW:0]      w_rnd_q;
    logic signed [AW:0]      w_sh_i;
    logic signed [AW:0]      w_sh_q;
    logic [DSZ:0]            w_sat_i;
    logic [DSZ:0]            w_sat_q;

    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_OUT);
    assign ovf       = out_valid && r_ovf;
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MUL;
            S_MUL:   if (r_cnt == 2'd3) w_next = S_DRAIN;
            S_DRAIN: w_next = S_RND;
            S_RND:   w_next = S_OUT;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // product order: ii*li, iq*lq, ii*lq, iq*li
    assign w_mul_a = r_cnt[0] ? r_in_q : r_in_i;
    assign w_mul_b = (r_cnt[0] ^ r_cnt[1]) ? r_lo_q : r_lo_i;
    assign w_prod  = w_mul_a * w_mul_b;

`ifdef CX_MIXER_CONJ_EN
    assign w_neg = r_conj ? (r_pidx == 2'd2) : (r_pidx == 2'd1);
`else
    assign w_neg = (r_pidx == 2'd1);
`endif

    assign w_pext   = AW'(r_prod);
    assign w_addend = w_neg ? -w_pext : w_pext;

    assign w_rnd_i = (AW+1)'(r_acc_i) + RND_K;
    assign w_rnd_q = (AW+1)'(r_acc_q) + RND_K;
    assign w_sh_i  = w_rnd_i >>> (DSZ-1);
    assign w_sh_q  = w_rnd_q >>> (DSZ-1);

    // returns {saturated, value}
    function automatic logic [DSZ:0] sat(input logic signed [AW:0] v);
        logic [HW-1:0] hi;
        hi = v[AW:DSZ-1];
        if (hi == {HW{v[AW]}})
            return {1'b0, v[DSZ-1:0]};
        else if (v[AW])
            return {2'b11, {(DSZ-1){1'b0}}};
        else
            return {2'b10, {(DSZ-1){1'b1}}};
    endfunction

    assign w_sat_i = sat(w_sh_i);
    assign w_sat_q = sat(w_sh_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_pidx  <= '0;
            r_pvld  <= 1'b0;
            r_in_i  <= '0;
            r_in_q  <= '0;
            r_lo_i  <= '0;
            r_lo_q  <= '0;
            r_prod  <= '0;
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_out_i <= '0;
            r_out_q <= '0;
            r_ovf   <= 1'b0;
`ifdef CX_MIXER_CONJ_EN
            r_conj  <= 1'b0;
`endif
        end else begin
            r_pvld <= (r_state == S_MUL);
            r_pidx <= r_cnt;
            if (r_state == S_MUL) begin
                r_prod <= w_prod;
                r_cnt  <= r_cnt + 2'd1;
            end
            if (w_accept) begin
                r_in_i  <= in_i;
                r_in_q  <= in_q;
                r_lo_i  <= lo_i;
                r_lo_q  <= lo_q;
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_cnt   <= '0;
`ifdef CX_MIXER_CONJ_EN
                r_conj  <= conj;
`endif
            end else if (r_pvld) begin
                // products lag the counter by one cycle
                if (r_pidx[1]) r_acc_q <= r_acc_q + w_addend;
                else           r_acc_i <= r_acc_i + w_addend;
            end
            if (r_state == S_RND) begin
                r_out_i <= w_sat_i[DSZ-1:0];
                r_out_q <= w_sat_q[DSZ-1:0];
                r_ovf   <= w_sat_i[DSZ] | w_sat_q[DSZ];
            end
        end
    end

endmodule

// File: tb/tb_cx_mixer.sv
// Self-checking bench for cx_mixer (DSZ=16) with a scoreboard queue.
// Exercises the conj path when CX_MIXER_CONJ_EN is defined.
module tb_cx_mixer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_i = '0;
    logic [15:0] in_q = '0;
    logic [15:0] lo_i = '0;
    logic [15:0] lo_q = '0;
    logic        conj_r = 1'b0;
    logic        out_valid;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        ovf;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic        ovf;
        int          tag;
    } exp_t;

    exp_t sbq[$];

    cx_mixer #(.DSZ(16), .GUARD(1)) dut (
        .clk(clk),
        .reset(reset),
`ifdef CX_MIXER_CONJ_EN
        .conj(conj_r),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_i(in_i),
        .in_q(in_q),
        .lo_i(lo_i),
        .lo_q(lo_q),
        .out_valid(out_valid),
        .out_i(out_i),
        .out_q(out_q),
        .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] c, input logic [15:0] d,
                                   input logic cj);
        exp_t m;
        longint ii, iq, li, lq, ri, rq;
        ii = longint'($signed(a));
        iq = longint'($signed(b));
        li = longint'($signed(c));
        lq = longint'($signed(d));
        if (cj) begin
            ri = ii*li + iq*lq;
            rq = iq*li - ii*lq;
        end else begin
            ri = ii*li - iq*lq;
            rq = ii*lq + iq*li;
        end
        ri = (ri + 16384) >>> 15;
        rq = (rq + 16384) >>> 15;
        m.ovf = 1'b0;
        if (ri > 32767)  begin ri = 32767;  m.ovf = 1'b1; end
        if (ri < -32768) begin ri = -32768; m.ovf = 1'b1; end
        if (rq > 32767)  begin rq = 32767;  m.ovf = 1'b1; end
        if (rq < -32768) begin rq = -32768; m.ovf = 1'b1; end
        m.i = ri[15:0];
        m.q = rq[15:0];
        m.tag = 0;
        return m;
    endfunction

    // drive one sample until accepted, then push its expectation
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d,
                        input logic cj, input exp_t e);
        bit ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_i = a; in_q = b; lo_i = c; lo_q = d; conj_r = cj;
            #1;
            if (in_ready) begin
                ok = 1;
                e.tag = cyc;
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
    endtask

    task automatic get_out(output bit got);
        got = 0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) got = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b exp=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags out_valid=%0b ovf=%0b exp=0,0", out_valid, ovf);
        end
        checks++;
        if (out_i !== 16'h0 || out_q !== 16'h0) begin
            failures++;
            $display("FAIL reset_out got=%h,%h exp=0000,0000", out_i, out_q);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%0b exp=1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] vi[4] = '{16'h4000, 16'h8000, 16'h0001, 16'h0000};
        logic [15:0] vq[4] = '{16'h0000, 16'h8000, 16'h0000, 16'h4000};
        logic [15:0] li[4] = '{16'h4000, 16'h8000, 16'h4000, 16'h0000};
        logic [15:0] lq[4] = '{16'h0000, 16'h8000, 16'h0000, 16'h4000};
        logic [15:0] ei[4] = '{16'h2000, 16'h0000, 16'h0001, 16'hE000};
        logic [15:0] eq[4] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
        logic        eo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_t e;
        bit got;
        for (int k = 0; k < 4; k++) begin
            e.i = ei[k]; e.q = eq[k]; e.ovf = eo[k]; e.tag = 0;
            send(vi[k], vq[k], li[k], lq[k], 1'b0, e);
            get_out(got);
            checks++;
            if (!got || sbq.size() == 0) begin
                failures++;
                $display("FAIL dir%0d_no_out out_valid=%0b exp=1", k, out_valid);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (out_i !== e.i || out_q !== e.q) begin
                    failures++;
                    $display("FAIL dir%0d_data got=%h,%h exp=%h,%h", k, out_i, out_q, e.i, e.q);
                end
                checks++;
                if (ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL dir%0d_ovf got=%0b exp=%0b", k, ovf, e.ovf);
                end
                checks++;
                if (cyc - e.tag !== 7) begin
                    failures++;
                    $display("FAIL dir%0d_latency got=%0d exp=7", k, cyc - e.tag);
                end
                @(negedge clk);
                #1;
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL dir%0d_strobe valid=%0b ready=%0b ovf=%0b exp=0,1,0",
                             k, out_valid, in_ready, ovf);
                end
                repeat (3) @(negedge clk);
                checks++;
                if (out_i !== e.i || out_q !== e.q) begin
                    failures++;
                    $display("FAIL dir%0d_hold got=%h,%h exp=%h,%h", k, out_i, out_q, e.i, e.q);
                end
            end
            sbq.delete();
        end
    endtask

`ifdef CX_MIXER_CONJ_EN
    task automatic test_conj();
        logic        cj[2] = '{1'b1, 1'b0};
        logic [15:0] ei[2] = '{16'h2000, 16'hE000};
        exp_t e;
        bit got;
        for (int k = 0; k < 2; k++) begin
            e.i = ei[k]; e.q = 16'h0000; e.ovf = 1'b0; e.tag = 0;
            send(16'h0000, 16'h4000, 16'h0000, 16'h4000, cj[k], e);
            get_out(got);
            checks++;
            if (!got || sbq.size() == 0) begin
                failures++;
                $display("FAIL conj%0d_no_out out_valid=%0b exp=1", k, out_valid);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (out_i !== e.i || out_q !== e.q || ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL conj%0d_data got=%h,%h,%0b exp=%h,%h,%0b",
                             k, out_i, out_q, ovf, e.i, e.q, e.ovf);
                end
            end
            sbq.delete();
            conj_r = 1'b0;
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] a, b, c, d;
        logic        cj;
        exp_t e;
        bit got;
        for (int k = 0; k < 10; k++) begin
            a = (k == 0) ? 16'h8000 : 16'($urandom);
            b = (k == 1) ? 16'h7FFF : 16'($urandom);
            c = (k < 2)  ? 16'h8000 : 16'($urandom);
            d = (k == 1) ? 16'h8000 : 16'($urandom);
`ifdef CX_MIXER_CONJ_EN
            cj = 1'(k);
`else
            cj = 1'b0;
`endif
            e = model(a, b, c, d, cj);
            send(a, b, c, d, cj, e);
            get_out(got);
            checks++;
            if (!got || sbq.size() == 0) begin
                failures++;
                $display("FAIL rnd%0d_no_out out_valid=%0b exp=1", k, out_valid);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (out_i !== e.i || out_q !== e.q || ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL rnd%0d_data got=%h,%h,%0b exp=%h,%h,%0b",
                             k, out_i, out_q, ovf, e.i, e.q, e.ovf);
                end
            end
            sbq.delete();
        end
        conj_r = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, c, d;
        exp_t e;
        int last = -1;
        int nacc = 0;
        int nout = 0;
        @(negedge clk);
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            c = 16'($urandom); d = 16'($urandom);
            in_valid = 1'b1;
            in_i = a; in_q = b; lo_i = c; lo_q = d;
            #1;
            if (out_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_spurious out_valid=1 exp=0");
                end else begin
                    e = sbq.pop_front();
                    nout++;
                    if (out_i !== e.i || out_q !== e.q || ovf !== e.ovf ||
                        cyc - e.tag !== 7) begin
                        failures++;
                        $display("FAIL b2b_data got=%h,%h,%0b lat=%0d exp=%h,%h,%0b lat=7",
                                 out_i, out_q, ovf, cyc - e.tag, e.i, e.q, e.ovf);
                    end
                end
            end
            if (last >= 0 && cyc - last < 8) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_busy_ready got=%0b exp=0 at +%0d", in_ready, cyc - last);
                end
            end
            if (in_ready) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 8) begin
                        failures++;
                        $display("FAIL b2b_spacing got=%0d exp=8", cyc - last);
                    end
                end
                e = model(a, b, c, d, 1'b0);
                e.tag = cyc;
                sbq.push_back(e);
                last = cyc;
                nacc++;
            end
        end
        in_valid = 1'b0;
        if (last == cyc) begin
            void'(sbq.pop_back());
            nacc--;
        end
        for (int k = 0; k < 16 && sbq.size() > 0; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                e = sbq.pop_front();
                nout++;
                checks++;
                if (out_i !== e.i || out_q !== e.q || ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL b2b_drain got=%h,%h,%0b exp=%h,%h,%0b",
                             out_i, out_q, ovf, e.i, e.q, e.ovf);
                end
            end
        end
        checks++;
        if (nacc < 6 || nout !== nacc) begin
            failures++;
            $display("FAIL b2b_count accepts=%0d outputs=%0d exp>=6 and equal", nacc, nout);
        end
        sbq.delete();
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int seen = 0;
        e = model(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0);
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, e);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_reset ready=%0b valid=%0b exp=0,0", in_ready, out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_release_ready got=%0b exp=1", in_ready);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_output got=%0d strobes exp=0", seen);
        end
        sbq.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef CX_MIXER_CONJ_EN
        test_conj();
`endif
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_directed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycles=%0d limit=20000", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cx_mixer.md
CX_MIXER -- requirements
Module: cx_mixer

Interface
REQ-001 SHALL have parameter DSZ, default 16, data word size in bits (range 8..24).
REQ-002 SHALL have parameter GUARD, default 1, extra accumulator bits above 2*DSZ.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input sample qualifier.
REQ-006 SHALL have port in_ready  output  1  block can accept a sample.
REQ-007 SHALL have port in_i / in_q  input  DSZ each  signed complex input, Q1.(DSZ-1).
REQ-008 SHALL have port lo_i / lo_q  input  DSZ each  signed complex LO, Q1.(DSZ-1).
REQ-009 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-010 SHALL have port out_i / out_q  output  DSZ each  signed complex product.
REQ-011 SHALL have port ovf  output  1  saturation flag, qualified by out_valid.

Function
REQ-012 SHALL compute out_i = in_i*lo_i - in_q*lo_q and out_q = in_i*lo_q + in_q*lo_i.
REQ-013 SHALL compute all four products with one shared signed DSZ x DSZ multiplier, time-multiplexed.
REQ-014 SHALL use FSM states IDLE -> MUL (4 cycles, product counter 0..3) -> DRAIN (1) -> RND (1) -> OUT (1) -> IDLE.
REQ-015 SHALL drive in_ready high only in IDLE and never during reset.
REQ-016 SHALL accept a sample on any edge with in_valid && in_ready, capturing in_i/in_q/lo_i/lo_q (and conj) into holding registers.
REQ-017 SHALL ignore in_valid when in_ready is low; no input is queued.
REQ-018 SHALL assert out_valid for exactly one cycle, on the 7th rising edge after the accepting edge.
REQ-019 SHALL reassert in_ready in the cycle following out_valid; maximum throughput is 1 sample / 8 cycles.
REQ-020 SHALL accumulate products in 2*DSZ+GUARD bits with no intermediate truncation.
REQ-021 SHALL round half-up by adding 2^(DSZ-2), then arithmetic-shift right by DSZ-1.
REQ-022 SHALL saturate each rounded result to [-2^(DSZ-1), 2^(DSZ-1)-1].
REQ-023 SHALL set ovf with out_valid when either component saturated; otherwise ovf = 0.
REQ-024 SHALL hold out_i/out_q stable between out_valid strobes.

Reset
REQ-025 SHALL, while reset is high, force FSM to IDLE, and force in_ready, out_valid, ovf to 0 and out_i, out_q, accumulators and holding registers to 0.
REQ-026 SHALL abandon any in-flight sample on reset, producing no out_valid for it.
REQ-027 SHALL drive in_ready high on the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with macro CX_MIXER_CONJ_EN defined, add port conj  input  1, sampled on accept; conj=1 mixes with conj(LO): out_i = in_i*lo_i + in_q*lo_q, out_q = in_q*lo_i - in_i*lo_q.
REQ-029 SHALL, without CX_MIXER_CONJ_EN, omit port conj and behave as conj=0 with no conj-related logic.

Verification (DSZ=16)
REQ-030 SHALL verify: in=(0x4000,0), lo=(0x4000,0) -> out=(0x2000,0x0000), ovf=0, out_valid 7 edges after accept.
REQ-031 SHALL verify: in=(0x8000,0x8000), lo=(0x8000,0x8000) -> out_i=0x0000, out_q=0x7FFF, ovf=1.
REQ-032 SHALL verify: in_valid held high continuously -> accepts spaced exactly 8 cycles; in_ready=0 during MUL..OUT.
REQ-033 SHALL verify: reset asserted 3 cycles after accept -> no out_valid for that sample; in_ready=1 first cycle after reset release.
REQ-034 SHALL verify (CX_MIXER_CONJ_EN): in=(0,0x4000), lo=(0,0x4000), conj=1 -> out=(0x2000,0x0000); conj=0 -> out=(0xE000,0x0000).
REQ-035 SHALL verify: in=(0x0001,0), lo=(0x4000,0) -> out_i=0x0001 (round half-up of 0.5 LSB).
